// File: rtl/pulse_pkg.sv
// pulse_pkg: shared state encoding, path-select constants and default widths for the burst sequencer
package pulse_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int CNT_W_DEF = 8;
    localparam int LSN_W_DEF = 16;
    localparam logic FREQ_1M = 1'b0;
    localparam logic FREQ_5M = 1'b1;
    typedef enum logic [2:0] {IDLE, ARM, BURST, LISTEN, DONE} state_t;
endpackage

// File: rtl/burst_len_counter.sv
// burst_len_counter: sample counter nested in a period counter; flags the final sample of the final period
module burst_len_counter #(
    parameter int ADDR_W = 10,
    parameter int CNT_W = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] periods,
    output logic             last_cycle
);
    logic [ADDR_W-1:0] samp_q, samp_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic samp_wrap;

    // sample count tracks the sender ROM address; periods count down on each wrap
    always_comb begin
        samp_wrap = &samp_q;
        last_cycle = en && samp_wrap && per_q == CNT_W'(1);
        samp_d = load ? '0 : en ? samp_q + ADDR_W'(1) : samp_q;
        per_d = load ? periods : (en && samp_wrap) ? per_q - CNT_W'(1) : per_q;
    end

    // counter registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            samp_q <= '0;
            per_q <= '0;
        end else begin
            samp_q <= samp_d;
            per_q <= per_d;
        end
    end
endmodule

// File: rtl/pulse_burst_ctrl.sv
// pulse_burst_ctrl: releases one DA address reset for whole ROM periods and frames the burst for ADC capture
module pulse_burst_ctrl
    import pulse_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int LSN_W = LSN_W_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic             abort,
    input  logic             freq_sel,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [LSN_W-1:0] listen_len,
    output logic             wave_rst_n,
    output logic             wave_rst1_n,
    output logic             adc_trig,
    output logic             capture_en,
    output logic             busy,
    output logic             done,
    output logic             aborted
);
    state_t state_q, state_d;
    logic freq_q, freq_d;
    logic [LSN_W-1:0] lsn_q, lsn_d;
    logic wave_rst_n_q, wave_rst_n_d;
    logic wave_rst1_n_q, wave_rst1_n_d;
    logic adc_trig_q, adc_trig_d;
    logic capture_en_q, capture_en_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic aborted_q, aborted_d;
    logic load, last_cycle, abort_hit, burst_on;

    burst_len_counter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_cnt (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .load(load),
        .en(state_q == BURST),
        .periods(burst_len),
        .last_cycle(last_cycle)
    );

    // next state, parameter latching and listen countdown; abort overrides everything
    always_comb begin
        state_d = state_q;
        freq_d = freq_q;
        lsn_d = lsn_q;
        load = 1'b0;
        abort_hit = abort && state_q != IDLE;
        case (state_q)
            IDLE: if (start && burst_len != '0) begin
                state_d = ARM;
                freq_d = freq_sel;
                lsn_d = listen_len;
                load = 1'b1;
            end
            ARM: state_d = BURST;
            BURST: if (last_cycle) state_d = (lsn_q != '0) ? LISTEN : DONE;
            LISTEN: begin
                lsn_d = lsn_q - LSN_W'(1);
                if (lsn_q == LSN_W'(1)) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_hit) state_d = IDLE;
    end

    // outputs follow the current state one register later; an abort clears all but the aborted pulse
    always_comb begin
        burst_on = state_q == BURST && !abort_hit;
        wave_rst_n_d = burst_on && freq_q == FREQ_1M;
        wave_rst1_n_d = burst_on && freq_q == FREQ_5M;
        adc_trig_d = burst_on && !(wave_rst_n_q || wave_rst1_n_q);
        capture_en_d = !abort_hit && (state_q == BURST || state_q == LISTEN);
        busy_d = !abort_hit && state_q != IDLE;
        done_d = !abort_hit && state_q == DONE;
        aborted_d = abort_hit;
    end

    // state, latched parameters and output registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            freq_q <= 1'b0;
            lsn_q <= '0;
            wave_rst_n_q <= 1'b0;
            wave_rst1_n_q <= 1'b0;
            adc_trig_q <= 1'b0;
            capture_en_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            freq_q <= freq_d;
            lsn_q <= lsn_d;
            wave_rst_n_q <= wave_rst_n_d;
            wave_rst1_n_q <= wave_rst1_n_d;
            adc_trig_q <= adc_trig_d;
            capture_en_q <= capture_en_d;
            busy_q <= busy_d;
            done_q <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign wave_rst_n = wave_rst_n_q;
    assign wave_rst1_n = wave_rst1_n_q;
    assign adc_trig = adc_trig_q;
    assign capture_en = capture_en_q;
    assign busy = busy_q;
    assign done = done_q;
    assign aborted = aborted_q;
endmodule
